// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit: access sizes,
// FSM states, timeout counter width and the alignment rule.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int CNT_W = 10;

  // Size encoding 2'b11 is treated as a word access, like 2'b10.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size == SZ_BYTE) return 1'b0;
    if (size == SZ_HALF) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port: store byte enables and data
// replication on the request side, load lane extract and extend on the response side.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  req_off,
  input  logic [1:0]  req_size,
  input  logic [31:0] store_data,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata,
  input  logic [1:0]  rsp_off,
  input  logic [1:0]  rsp_size,
  input  logic        rsp_signed,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    byte_en    = 4'b1111;
    lane_wdata = store_data;
    if (req_size == SZ_BYTE) begin
      byte_en    = 4'b0001 << req_off;
      lane_wdata = {4{store_data[7:0]}};
    end else if (req_size == SZ_HALF) begin
      byte_en    = 4'b0011 << {req_off[1], 1'b0};
      lane_wdata = {2{store_data[15:0]}};
    end
  end

  always_comb begin
    lane_b    = rdata[{rsp_off, 3'b000} +: 8];
    lane_h    = rsp_off[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    if (rsp_size == SZ_BYTE)
      load_data = rsp_signed ? 32'(lane_b) : {24'b0, lane_b};
    else if (rsp_size == SZ_HALF)
      load_data = rsp_signed ? 32'(lane_h) : {16'b0, lane_h};
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues one registered request per access on a
// variable-latency data-memory port and stalls the pipeline until it completes.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic        RegWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        RegWriteGatedM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             sgn_q;
  logic             load_q;
  logic             access;
  logic             start;
  logic [3:0]       req_be;
  logic [31:0]      req_wdata;
  logic [31:0]      load_data;

  assign access         = MemReadM | MemWriteM;
  assign MisalignM      = access & misaligned(MemSizeM, ALUOutM[1:0]);
  assign start          = (state == ST_IDLE) & access & ~MisalignM;
  assign StallM         = start | (state == ST_REQ);
  assign RegWriteGatedM = RegWriteM & ~MisalignM & ~BusErrM;

  // Response side uses the fields latched at request time, not the live inputs.
  mem_lane_align u_align (
    .req_off    (ALUOutM[1:0]),
    .req_size   (MemSizeM),
    .store_data (WriteDataM),
    .byte_en    (req_be),
    .lane_wdata (req_wdata),
    .rsp_off    (off_q),
    .rsp_size   (size_q),
    .rsp_signed (sgn_q),
    .rdata      (dmem_rdata),
    .load_data  (load_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      ReadDataM  <= '0;
      BusErrM    <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= ALUOutM[31:2];
            dmem_be    <= req_be;
            dmem_wdata <= req_wdata;
            off_q      <= ALUOutM[1:0];
            size_q     <= MemSizeM;
            sgn_q      <= MemSignedM;
            load_q     <= MemReadM & ~MemWriteM;
            cnt        <= '0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack on the last allowed cycle still wins over the timeout.
          if (dmem_ack) begin
            if (load_q) ReadDataM <= load_data;
            dmem_req <= 1'b0;
            state    <= ST_DONE;
          end else if (cnt == LAST) begin
            BusErrM   <= 1'b1;
            ReadDataM <= '0;
            dmem_req  <= 1'b0;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          BusErrM <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage data-memory access unit of the 5-stage MIPS32 pipeline. It sits between the EX/MEM register and the MEM/WB register. It turns load/store control plus the ALU address into a byte-lane request on a variable-latency data-memory port. It stalls the pipeline until the access completes, and delivers aligned, extended load data (ReadDataM) and a gated RegWrite to the MEM/WB register.

## Interface
- TIMEOUT, 255: max cycles in REQ without dmem_ack before bus error (1..1023).
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- MemReadM  in  1  load in MEM.
- MemWriteM  in  1  store in MEM.
- MemSizeM  in  2  00 byte, 01 half, 10/11 word.
- MemSignedM  in  1  sign-extend byte/half loads.
- RegWriteM  in  1  instruction writes a register.
- ALUOutM  in  32  effective address.
- WriteDataM  in  32  store data (low bits used for byte/half).
- ReadDataM  out  32  aligned/extended load result, registered.
- RegWriteGatedM  out  1  RegWriteM & ~MisalignM & ~BusErrM.
- StallM  out  1  holds PC, IF/ID, ID/EX, EX/MEM; MEM/WB loads a bubble.
- MisalignM  out  1  combinational misaligned-access flag.
- BusErrM  out  1  registered timeout flag, valid in DONE.
- dmem_req  out  1  request valid, registered.
- dmem_we  out  1  write enable, registered.
- dmem_addr  out  30  word address ALUOutM[31:2], registered.
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian), registered.
- dmem_wdata  out  32  lane-replicated store data, registered.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- dmem_ack  in  1  one-cycle completion pulse.

## Operation
- States: IDLE, REQ, DONE.
- access = MemReadM | MemWriteM. Both high: treat as store, no load data.
- MisalignM = access & ((half & ALUOutM[0]) | (word & ALUOutM[1:0]!=0)). Misaligned access: no request, no stall, stays IDLE.
- IDLE, access & ~MisalignM: register dmem_* outputs, counter := 0, go REQ.
- REQ: dmem_req held at 1 with stable fields until dmem_ack.
  - On ack: ReadDataM := extracted lane, dmem_req := 0, go DONE. ReadDataM keeps its previous value for stores.
  - Counter increments each REQ cycle. Counter reaching TIMEOUT-1 with no ack: BusErrM := 1, ReadDataM := 0, dmem_req := 0, go DONE.
- DONE: unconditional return to IDLE next cycle; BusErrM cleared on exit.
- Byte enables: byte 0001<<a[1:0]; half 0011<<{a[1],1'b0}; word 1111.
- Write data: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
- Load extract: byte lane a[1:0], half lane a[1]; zero- or sign-extended per MemSignedM; word unchanged.
- dmem_ack outside REQ is ignored.
- RST in any state: state IDLE, dmem_req/we 0, dmem_addr/be/wdata 0, ReadDataM 0, BusErrM 0, counter 0. In-flight ack is ignored after reset.

## Timing
- StallM = (IDLE & access & ~MisalignM) | REQ. Deasserted in DONE so MEM/WB captures ReadDataM at the end of DONE.
- Zero-wait memory (ack in first REQ cycle): access occupies 3 cycles (IDLE-detect, REQ, DONE) with 2 stall cycles.
- Memory with N wait cycles: 3+N cycles.
- Non-memory instructions: 0 added cycles, StallM=0.
- The EX/MEM inputs are held stable by StallM through IDLE-detect, REQ, and DONE. The block does not re-sample them mid-access.
- DONE always spends one cycle in IDLE before the next access; back-to-back accesses are separated by that IDLE cycle.

## Structure
- Package mem_stage_pkg:
  - MemSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - State enum (ST_IDLE, ST_REQ, ST_DONE).
  - Counter width constant (10 bits).
- Sub-module mem_lane_align: combinational byte-enable generation, write-data replication, and load extract/extend.
- The FSM, counter, and registers stay in the top module.

## Test plan
- Load byte signed, addr 0x1003, rdata 0x80FF_FF7F, ack in first REQ cycle -> ReadDataM 0xFFFF_FF80, dmem_be 1000, StallM high 2 cycles.
- Store half, addr 0x2002, WriteDataM 0x0000_BEEF, ack after 3 wait cycles -> dmem_be 1100, dmem_wdata 0xBEEF_BEEF, dmem_we 1, StallM high 5 cycles.
- Load word addr 0x3001 -> MisalignM 1, dmem_req never asserted, StallM 0, RegWriteGatedM 0.
- Load word with ack withheld, TIMEOUT=4 -> BusErrM 1 in DONE, ReadDataM 0, dmem_req drops after 4 REQ cycles.
- RST asserted in REQ with ack the following cycle -> state IDLE, dmem_req 0, ReadDataM unchanged at 0, ack ignored.
- Back-to-back lw/sw, zero-wait -> each access 3 cycles, one IDLE cycle between them, no lost ack.
